// File: rtl/palette_ctrl_if.sv
// rtl/palette_ctrl_if.sv - palette write-request bundle for two requesters
interface palette_ctrl_if;
   logic        req0_valid;
   logic [3:0]  req0_idx;
   logic [23:0] req0_color;
   logic        req0_ready;
   logic        req1_valid;
   logic [3:0]  req1_idx;
   logic [23:0] req1_color;
   logic        req1_ready;

   modport master (
      output req0_valid, req0_idx, req0_color,
      output req1_valid, req1_idx, req1_color,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_idx, req0_color,
      input  req1_valid, req1_idx, req1_color,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/palette_ctrl.sv
// rtl/palette_ctrl.sv - shadow/live 16x24 palette with vblank commit; optional fade via PALETTE_FADE_EN
module palette_ctrl #(
   parameter int NUM_ENTRIES = 16,
   parameter int COLOR_W     = 24
) (
   input  logic               Clk,
   input  logic               Reset_n,
   palette_ctrl_if.slave      req,
   input  logic               vblank_start,
   input  logic               commit,
   output logic               commit_pending,
   output logic               busy,
   input  logic               fade_start,
   input  logic               fade_clear,
   input  logic [3:0]         rd_idx,
   output logic [COLOR_W-1:0] rd_color
);

   typedef enum logic [1:0] {IDLE, PEND, COPY} state_t;

   state_t             state_q;
   logic [3:0]         cnt_q;
   logic               rp_q;
   logic               commit_pending_q;
   logic               busy_q;
   logic [COLOR_W-1:0] shadow_q [NUM_ENTRIES];
   logic [COLOR_W-1:0] live_q   [NUM_ENTRIES];

   logic               gnt0, gnt1, wr_en;
   logic [3:0]         wr_idx;
   logic [COLOR_W-1:0] wr_color;

   function automatic logic [COLOR_W-1:0] dflt(input int i);
      case (i)
         0:       return 24'hff00ff;
         1:       return 24'h2d2d0c;
         2:       return 24'h282807;
         3:       return 24'h202000;
         default: return '0;
      endcase
   endfunction

   // Round-robin pointer only matters on contention; nothing is granted during COPY.
   assign gnt0 = (state_q != COPY) && req.req0_valid && (!req.req1_valid || !rp_q);
   assign gnt1 = (state_q != COPY) && req.req1_valid && (!req.req0_valid ||  rp_q);
   assign req.req0_ready = gnt0;
   assign req.req1_ready = gnt1;
   assign wr_en    = gnt0 || gnt1;
   assign wr_idx   = gnt0 ? req.req0_idx   : req.req1_idx;
   assign wr_color = gnt0 ? req.req0_color : req.req1_color;

   assign commit_pending = commit_pending_q;
   assign busy           = busy_q;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         rp_q             <= 1'b0;
         commit_pending_q <= 1'b0;
         busy_q           <= 1'b0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            shadow_q[i] <= dflt(i);
            live_q[i]   <= dflt(i);
         end
      end else begin
         if (wr_en) begin
            shadow_q[wr_idx] <= wr_color;
            rp_q             <= gnt0;
         end
         case (state_q)
            IDLE: begin
               if (commit) begin
                  state_q          <= PEND;
                  commit_pending_q <= 1'b1;
               end
            end
            PEND: begin
               if (vblank_start) begin
                  state_q          <= COPY;
                  cnt_q            <= '0;
                  commit_pending_q <= 1'b0;
                  busy_q           <= 1'b1;
               end
            end
            COPY: begin
               live_q[cnt_q] <= shadow_q[cnt_q];
               cnt_q         <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q          <= IDLE;
               commit_pending_q <= 1'b0;
               busy_q           <= 1'b0;
            end
         endcase
      end
   end

`ifdef PALETTE_FADE_EN
   logic [2:0]         fade_lvl_q;
   logic               fade_active_q;
   logic [COLOR_W-1:0] live_rd;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         fade_lvl_q    <= '0;
         fade_active_q <= 1'b0;
      end else if (fade_clear) begin
         fade_lvl_q    <= '0;
         fade_active_q <= 1'b0;
      end else begin
         if (fade_start) fade_active_q <= 1'b1;
         if (vblank_start && fade_active_q && fade_lvl_q != 3'd7)
            fade_lvl_q <= fade_lvl_q + 3'd1;
      end
   end

   // Product never exceeds 255*8, so 11 bits hold it exactly.
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [2:0] lvl);
      logic [10:0] p;
      p = {3'b000, c} * {7'b0000000, 4'd8 - {1'b0, lvl}};
      return p[10:3];
   endfunction

   assign live_rd  = live_q[rd_idx];
   assign rd_color = {scale(live_rd[23:16], fade_lvl_q),
                      scale(live_rd[15:8],  fade_lvl_q),
                      scale(live_rd[7:0],   fade_lvl_q)};
`else
   logic unused_fade;
   assign unused_fade = fade_start ^ fade_clear;
   assign rd_color    = live_q[rd_idx];
`endif

endmodule

// File: tb/tb_palette_ctrl.sv
// tb/tb_palette_ctrl.sv - scoreboard bench for palette_ctrl (directed vectors)
module tb_palette_ctrl;

   logic        Clk;
   logic        Reset_n;
   logic        vblank_start, commit, fade_start, fade_clear;
   logic        commit_pending, busy;
   logic [3:0]  rd_idx;
   logic [23:0] rd_color;

   palette_ctrl_if bus ();

   palette_ctrl dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .req            (bus.slave),
      .vblank_start   (vblank_start),
      .commit         (commit),
      .commit_pending (commit_pending),
      .busy           (busy),
      .fade_start     (fade_start),
      .fade_clear     (fade_clear),
      .rd_idx         (rd_idx),
      .rd_color       (rd_color)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      int          kind;   // 0 rd_color, 1 busy, 2 commit_pending, 3 ready0, 4 ready1
      logic [23:0] exp;
      string       name;
   } sample_t;

   sample_t sq[$];
   int      gq[$];
   int      bq[$];
   int      n_tests = 0;
   int      n_fail  = 0;
   int      busy_run = 0;
   sample_t it;

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input int act, input int exp);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [23:0] actual(input int kind);
      case (kind)
         0:       return rd_color;
         1:       return {23'd0, busy};
         2:       return {23'd0, commit_pending};
         3:       return {23'd0, bus.req0_ready};
         default: return {23'd0, bus.req1_ready};
      endcase
   endfunction

   task automatic grant_seen(input int id);
      int e;
      if (gq.size() == 0) fail_now("grant_unexpected", id, -1);
      else begin
         e = gq.pop_front();
         check("grant_order", id[23:0], e[23:0]);
      end
   endtask

   // Monitor: compares everything the DUT presents at the falling edge
   always @(negedge Clk) begin
      while (sq.size() > 0) begin
         it = sq.pop_front();
         check(it.name, actual(it.kind), it.exp);
      end
      if (bus.req0_valid && bus.req0_ready) grant_seen(0);
      if (bus.req1_valid && bus.req1_ready) grant_seen(1);
      if (bus.req0_ready && bus.req1_ready) fail_now("double_grant", 2, 1);
      if (commit_pending === 1'b1 && busy === 1'b1) fail_now("pend_and_busy", 1, 0);
      if (busy === 1'b1) busy_run++;
      else if (busy_run > 0) begin
         if (bq.size() == 0) fail_now("copy_unexpected", busy_run, 0);
         else check("busy_cycles", bq.pop_front(), busy_run);
         busy_run = 0;
      end
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic expect_s(input int kind, input logic [23:0] exp, input string name);
      sample_t s;
      s.kind = kind;
      s.exp  = exp;
      s.name = name;
      sq.push_back(s);
   endtask

   task automatic wait_idle;
      int k;
      k = 0;
      while (busy && k < 40) begin
         tick;
         k++;
      end
      if (busy) fail_now("copy_timeout", k, 16);
      tick;
   endtask

   task automatic write0(input logic [3:0] idx, input logic [23:0] c);
      bus.req0_valid = 1'b1; bus.req0_idx = idx; bus.req0_color = c;
      gq.push_back(0);
      tick;
      bus.req0_valid = 1'b0;
   endtask

   task automatic write1(input logic [3:0] idx, input logic [23:0] c);
      bus.req1_valid = 1'b1; bus.req1_idx = idx; bus.req1_color = c;
      gq.push_back(1);
      tick;
      bus.req1_valid = 1'b0;
   endtask

   task automatic do_commit_copy;
      commit = 1'b1; tick; commit = 1'b0; tick;
      vblank_start = 1'b1; bq.push_back(16); tick; vblank_start = 1'b0;
      wait_idle;
   endtask

   initial begin
      Reset_n = 1'b0; vblank_start = 1'b0; commit = 1'b0;
      fade_start = 1'b0; fade_clear = 1'b0; rd_idx = 4'd0;
      bus.req0_valid = 1'b0; bus.req0_idx = '0; bus.req0_color = '0;
      bus.req1_valid = 1'b0; bus.req1_idx = '0; bus.req1_color = '0;
      repeat (2) tick;

      // Reset state
      rd_idx = 4'd1; expect_s(0, 24'h2d2d0c, "rst_rd1");
      expect_s(1, 24'd0, "rst_busy"); expect_s(2, 24'd0, "rst_pending");
      tick;
      Reset_n = 1'b1;
      rd_idx = 4'd5; expect_s(0, 24'h000000, "rst_rd5"); tick;
      rd_idx = 4'd0; expect_s(0, 24'hff00ff, "rst_rd0"); tick;

      // Solo requesters are granted; live bank untouched by writes
      expect_s(3, 24'd1, "ready0_solo"); write0(4'd2, 24'h123456);
      rd_idx = 4'd2; expect_s(0, 24'h282807, "live_unchanged");
      expect_s(4, 24'd1, "ready1_solo"); write1(4'd9, 24'h0a0b0c);

      // Commit then vblank: entry 2 visible from edge 3
      commit = 1'b1; tick; commit = 1'b0;
      expect_s(2, 24'd1, "commit_pending"); expect_s(1, 24'd0, "busy_pend"); tick;
      tick;
      vblank_start = 1'b1; rd_idx = 4'd2; bq.push_back(16); tick; vblank_start = 1'b0;
      for (int e = 0; e < 5; e++) begin
         expect_s(0, (e >= 3) ? 24'h123456 : 24'h282807, $sformatf("copy_edge%0d", e));
         if (e == 0) begin
            expect_s(1, 24'd1, "busy_copy");
            expect_s(2, 24'd0, "pending_cleared");
         end
         tick;
      end
      wait_idle;
      rd_idx = 4'd9; expect_s(0, 24'h0a0b0c, "copied_idx9"); expect_s(1, 24'd0, "busy_done"); tick;

      // Contention: grants alternate 0,1,0,1; later grant wins idx 7
      bus.req0_valid = 1'b1; bus.req0_idx = 4'd7; bus.req0_color = 24'haabbcc;
      bus.req1_valid = 1'b1; bus.req1_idx = 4'd7; bus.req1_color = 24'hddeeff;
      for (int i = 0; i < 4; i++) begin
         gq.push_back(i % 2);
         tick;
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      rd_idx = 4'd7; expect_s(0, 24'h000000, "live7_before"); tick;

      // Write on the vblank edge is copied; commit during COPY is lost
      commit = 1'b1; tick; commit = 1'b0; tick;
      vblank_start = 1'b1; bq.push_back(16);
      bus.req0_valid = 1'b1; bus.req0_idx = 4'd4; bus.req0_color = 24'h445566;
      gq.push_back(0);
      tick;
      vblank_start = 1'b0;
      bus.req0_idx = 4'd11; bus.req0_color = 24'heeeeee;
      expect_s(3, 24'd0, "ready0_in_copy"); tick;
      bus.req0_valid = 1'b0;
      commit = 1'b1; tick; commit = 1'b0;
      wait_idle;
      rd_idx = 4'd7; expect_s(0, 24'hddeeff, "arb_later_wins"); tick;
      rd_idx = 4'd4; expect_s(0, 24'h445566, "vblank_edge_write");
      expect_s(2, 24'd0, "commit_lost"); tick;
      vblank_start = 1'b1; tick; vblank_start = 1'b0;
      repeat (3) begin expect_s(1, 24'd0, "no_second_copy"); tick; end

      // commit with vblank in IDLE: copy waits for the next vblank
      write1(4'd10, 24'h0000aa);
      commit = 1'b1; vblank_start = 1'b1; tick; commit = 1'b0; vblank_start = 1'b0;
      expect_s(2, 24'd1, "cv_pending"); expect_s(1, 24'd0, "cv_no_copy"); tick;
      rd_idx = 4'd10; expect_s(0, 24'h000000, "cv_live_old"); tick;
      vblank_start = 1'b1; bq.push_back(16); tick; vblank_start = 1'b0;
      wait_idle;
      rd_idx = 4'd10; expect_s(0, 24'h0000aa, "cv_copied"); tick;

      // Fade: two vblanks after fade_start scale by 6/8
      write0(4'd5, 24'hff8040);
      do_commit_copy;
      fade_start = 1'b1; tick; fade_start = 1'b0;
      rd_idx = 4'd5; expect_s(0, 24'hff8040, "fade_lvl0"); tick;
      vblank_start = 1'b1; tick; vblank_start = 1'b0; tick;
      vblank_start = 1'b1; tick; vblank_start = 1'b0;
`ifdef PALETTE_FADE_EN
      expect_s(0, 24'hbf6030, "fade_lvl2");
`else
      expect_s(0, 24'hff8040, "fade_ignored");
`endif
      tick;
      fade_clear = 1'b1; tick; fade_clear = 1'b0;
      expect_s(0, 24'hff8040, "fade_cleared"); tick;

      // Reset on cycle 5 of COPY
      write0(4'd1, 24'h111111);
      commit = 1'b1; tick; commit = 1'b0; tick;
      vblank_start = 1'b1; bq.push_back(5); tick; vblank_start = 1'b0;
      repeat (4) tick;
      Reset_n = 1'b0; tick;
      rd_idx = 4'd1; expect_s(0, 24'h2d2d0c, "rst_copy_live1");
      expect_s(1, 24'd0, "rst_copy_busy"); expect_s(2, 24'd0, "rst_copy_pending");
      tick;
      Reset_n = 1'b1;
      rd_idx = 4'd5; expect_s(0, 24'h000000, "rst_copy_live5"); tick;
      vblank_start = 1'b1; tick; vblank_start = 1'b0;
      repeat (2) begin expect_s(1, 24'd0, "rst_commit_dropped"); tick; end

      repeat (2) tick;
      check("grant_queue_empty", gq.size(), 0);
      check("copy_queue_empty", bq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/palette_ctrl.md
# palette_ctrl

Palette configuration controller for the VGA pixel path. It owns a 16-entry, 24-bit RGB palette and serves per-pixel lookups to the color mapper. Two requesters (level loader and effects engine) write entries through a round-robin arbiter into a shadow bank, and a shadow-to-live copy is scheduled into vertical blanking so that visible frames never tear. An optional frame-stepped fade scales the looked-up color.

## Interface
Parameters:
- NUM_ENTRIES, 16, palette depth. Fixed at 16, so the index width is 4.
- COLOR_W, 24, packed RGB width, laid out as {R[23:16], G[15:8], B[7:0]}.

Ports:
- Clk  in  1  system clock (VGA pixel domain).
- Reset_n  in  1  synchronous, active-low reset.
- vblank_start  in  1  one-cycle pulse at the start of vertical blanking.
- req0_valid  in  1  write request from requester 0 (level loader).
- req0_idx  in  4  palette index for requester 0.
- req0_color  in  24  RGB value for requester 0.
- req0_ready  out  1  grant for requester 0. The write happens when valid and ready are both high.
- req1_valid, req1_idx, req1_color, req1_ready  same as above, for requester 1 (effects engine).
- commit  in  1  pulse that requests a shadow-to-live copy at the next vblank_start.
- commit_pending  out  1  high while a copy is scheduled and has not yet started.
- busy  out  1  high while the copy is in progress.
- fade_start  in  1  pulse that starts the fade. Used only with the fade feature.
- fade_clear  in  1  pulse that cancels the fade and restores full brightness.
- rd_idx  in  4  lookup index from the pixel path.
- rd_color  out  24  color for rd_idx (combinational).

## Operation
- Two banks, shadow[16] and live[16]. Reset value of both banks:
  - entry 0 = ff00ff
  - entry 1 = 2d2d0c
  - entry 2 = 282807
  - entry 3 = 202000
  - entries 4–15 = 000000
- FSM states: IDLE, PEND, COPY. Reset state is IDLE.
- IDLE:
  - Writes are accepted.
  - commit moves the FSM to PEND.
- PEND:
  - Writes are accepted.
  - A further commit has no effect.
  - vblank_start moves the FSM to COPY and sets cnt to 0.
- COPY:
  - Each cycle copies live[cnt] ← shadow[cnt], then increments cnt.
  - After cnt=15 is copied, the FSM returns to IDLE.
  - commit, vblank_start and requests are all ignored in this state. A commit pulse that arrives during COPY is lost.
- Arbitration:
  - Readies are combinational and are low in COPY.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester selected by the round-robin pointer rp is granted.
  - rp moves to the other requester after every grant.
  - At most one write happens per cycle.
  - Reset value of rp is 0.
- A granted write updates shadow[idx] at the clock edge. The live bank is changed only by COPY.
- Simultaneous events:
  - commit together with vblank_start while in IDLE: go to PEND. The copy starts at the following vblank_start.
  - A write granted on the same edge as the vblank_start that enters COPY is included in the copy.
- rd_color = fade(live[rd_idx]).
- Reset during COPY: the FSM returns to IDLE, both banks return to their defaults, and the pending commit is dropped.
- Output reset values: req0_ready and req1_ready follow the arbiter; commit_pending=0; busy=0; rd_color = the default entry at rd_idx.

## Timing
- Handshake to shadow update: 1 edge.
- commit to commit_pending high: 1 edge.
- Entry k is visible on rd_color after edge k+1, counted from the vblank_start edge.
- busy is high for exactly 16 cycles. commit_pending and busy are never both high.
- Lookup: rd_idx to rd_color is purely combinational with zero latency.
- The copy completes in 16 cycles, which is well inside blanking. A mixed live bank during COPY is acceptable.

## Configuration
- PALETTE_FADE_EN defined:
  - A 3-bit fade_lvl register and a fade_active flag are built.
  - fade_start sets fade_active. Each vblank_start while fade_active is set increments fade_lvl, saturating at 7.
  - fade_clear sets fade_lvl=0 and fade_active=0. fade_clear wins over fade_start.
  - Each channel output = (c × (8−fade_lvl)) >> 3, truncated.
- PALETTE_FADE_EN undefined:
  - fade_start and fade_clear are ignored.
  - rd_color = live[rd_idx] exactly.
  - No fade registers are built.

## Test plan
- Reset → rd_idx=1 gives 2d2d0c; rd_idx=5 gives 000000; ready=1 on each requester that has valid high; busy=0.
- req0 writes idx 2 = 123456 → rd_idx=2 still gives 282807. Then commit followed by vblank_start → 282807 until edge 3 after vblank_start, then 123456 from edge 3 on. busy is high for 16 cycles.
- Both requesters valid every cycle for 4 cycles → grants alternate 0,1,0,1. Both writes to idx 7 (req0 aabbcc, req1 ddeeff): the value granted later wins in shadow.
- commit pulsed during COPY → no second copy. commit and vblank_start in the same cycle while in IDLE → copy starts only at the next vblank_start.
- With PALETTE_FADE_EN: entry ff8040, fade_start, then 2 vblank_start pulses → rd_color = bf6030. Then fade_clear → ff8040.
- Reset_n low on cycle 5 of COPY → IDLE, busy=0, live bank back to defaults, commit_pending=0.
